// File: rtl/wheel_speed_sampler_if.sv
// Delta output stream of the wheel speed sampler.
// valid/ready: the master raises spd_valid with spd_ch/spd_data and holds all three stable
// until a cycle in which spd_ready=1; the transfer happens on that rising clk edge.
interface wheel_speed_sampler_if #(
    parameter int CNT_W = 16
);
    logic             spd_valid;
    logic             spd_ready;
    logic [2:0]       spd_ch;
    logic [CNT_W-1:0] spd_data;

    modport master (
        output spd_valid,
        output spd_ch,
        output spd_data,
        input  spd_ready
    );

    modport slave (
        input  spd_valid,
        input  spd_ch,
        input  spd_data,
        output spd_ready
    );
endinterface

// File: rtl/wheel_speed_sampler.sv
// Periodic snapshot of all encoder counters, converted channel by channel into signed
// per-period deltas through one shared subtractor and streamed out in channel order.
module wheel_speed_sampler #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    parameter int PERIOD = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CH*CNT_W-1:0] enc_counts,
    input  logic                    clear_ovr,
    wheel_speed_sampler_if.master   spd,
    output logic                    overrun,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    localparam int CH_IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CH_IW-1:0] CH_LAST  = CH_IW'(NUM_CH - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [TMR_W-1:0] tmr;
    logic             tick;
    logic             primed;
    logic [CH_IW-1:0] ch;
    logic [CNT_W-1:0] snap [NUM_CH];
    logic [CNT_W-1:0] prev [NUM_CH];
    logic [CNT_W-1:0] delta;

    logic             spd_valid_q;
    logic [2:0]       spd_ch_q;
    logic [CNT_W-1:0] spd_data_q;

    logic             do_capture;
    logic             do_prime;
    logic             do_load;
    logic             do_accept;

    assign spd.spd_valid = spd_valid_q;
    assign spd.spd_ch    = spd_ch_q;
    assign spd.spd_data  = spd_data_q;
    assign dbg_state     = state;

    // ---------------- sample timer ----------------
    assign tick = enable && (tmr == TMR_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmr <= '0;
        end else if (!enable || tick) begin
            tmr <= '0;
        end else begin
            tmr <= tmr + TMR_W'(1);
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
        end
    end

    always_comb begin
        state_nxt  = state;
        do_capture = 1'b0;
        do_prime   = 1'b0;
        do_load    = 1'b0;
        do_accept  = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick) begin
                    do_capture = 1'b1;
                    if (!primed) begin
                        do_prime = 1'b1;
                    end else begin
                        state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                do_load   = 1'b1;
                state_nxt = S_SEND;
            end
            S_SEND: begin
                if (spd.spd_ready) begin
                    do_accept = 1'b1;
                    state_nxt = (ch == CH_LAST) ? S_IDLE : S_LOAD;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------- channel index and priming ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch <= '0;
        end else if (do_capture) begin
            ch <= '0;
        end else if (do_accept && (ch != CH_LAST)) begin
            ch <= ch + CH_IW'(1);
        end
    end

    // Leaving enable low while idle forgets the baseline, so the next tick only re-primes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            primed <= 1'b0;
        end else if (!enable && (state == S_IDLE)) begin
            primed <= 1'b0;
        end else if (do_prime) begin
            primed <= 1'b1;
        end
    end

    // ---------------- snapshot / baseline storage ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                snap[i] <= '0;
                prev[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (do_capture) begin
                    snap[i] <= enc_counts[i*CNT_W +: CNT_W];
                end
                if (do_prime) begin
                    prev[i] <= enc_counts[i*CNT_W +: CNT_W];
                end
            end
            if (do_load) begin
                prev[ch] <= snap[ch];
            end
        end
    end

    // Modular subtraction makes counter wrap-around come out as the correct signed delta.
    assign delta = snap[ch] - prev[ch];

    // ---------------- output stream ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spd_valid_q <= 1'b0;
            spd_ch_q    <= '0;
            spd_data_q  <= '0;
        end else if (do_load) begin
            spd_valid_q <= 1'b1;
            spd_ch_q    <= 3'(ch);
            spd_data_q  <= delta;
        end else if (do_accept) begin
            spd_valid_q <= 1'b0;
        end
    end

    // A tick that finds the FSM busy is dropped; the set takes priority over clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (tick && (state != S_IDLE)) begin
            overrun <= 1'b1;
        end else if (clear_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wheel_speed_sampler.sv
// Directed bench for wheel_speed_sampler: table of sample periods plus hand-written
// overrun, disable, and asynchronous-reset sequences.
module tb_wheel_speed_sampler;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int PERIOD = 16;

    logic                    clk;
    logic                    reset;
    logic                    enable;
    logic [NUM_CH*CNT_W-1:0] enc_counts;
    logic                    clear_ovr;
    logic                    overrun;
    logic                    busy;
    logic [1:0]              dbg_state;

    wheel_speed_sampler_if #(.CNT_W(CNT_W)) spd_if ();

    wheel_speed_sampler #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W),
        .PERIOD(PERIOD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .enc_counts(enc_counts),
        .clear_ovr (clear_ovr),
        .spd       (spd_if),
        .overrun   (overrun),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- counters and scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [18:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected deltas for one burst, packed {ch3,ch2,ch1,ch0}.
    task automatic push_exp(input logic [63:0] deltas);
        for (int k = 0; k < NUM_CH; k++) begin
            exp_q.push_back({3'(k), deltas[k*CNT_W +: CNT_W]});
        end
    endtask

    // Reference sample timer: tick when the count reaches PERIOD-1 while enabled.
    int   tb_tmr;
    logic tb_tick;
    always @(posedge clk) begin
        if (!reset || !enable) tb_tmr <= 0;
        else tb_tmr <= (tb_tmr == PERIOD - 1) ? 0 : tb_tmr + 1;
    end
    assign tb_tick = reset && enable && (tb_tmr == PERIOD - 1);

    // ---------------- output monitor ----------------
    logic        pv, pr;
    logic [2:0]  pch;
    logic [15:0] pdata;
    logic [18:0] e;
    always @(negedge clk) begin
        if (!reset) begin
            pv = 1'b0;
            pr = 1'b1;
        end else begin
            if (pv && !pr) begin
                check("hold_stable", {spd_if.spd_valid, spd_if.spd_ch, spd_if.spd_data},
                      {1'b1, pch, pdata});
            end
            if (spd_if.spd_valid && spd_if.spd_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", {spd_if.spd_ch, spd_if.spd_data}, 32'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("spd_out", {spd_if.spd_ch, spd_if.spd_data}, e);
                end
            end
            pv    = spd_if.spd_valid;
            pr    = spd_if.spd_ready;
            pch   = spd_if.spd_ch;
            pdata = spd_if.spd_data;
        end
    end

    // ---------------- driver tasks ----------------
    // Returns at the falling edge inside the tick cycle.
    task automatic wait_tick(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tb_tick && n < 3 * PERIOD);
        if (!tb_tick) check(name, 32'd0, 32'd1);
    endtask

    // After a priming tick the block must stay silent.
    task automatic prime_check(input string name);
        logic seen;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #2;
            if (busy || spd_if.spd_valid) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    // Drives spd_ready until the expected queue drains, optionally stalling one channel.
    task automatic run_burst(input bit chk_lat, input int stall_ch, input int stall_len);
        int c;
        int stalled;
        c = 0;
        stalled = 0;
        while (exp_q.size() != 0 && c < 100) begin
            @(posedge clk);
            #2;
            c++;
            if (chk_lat && c == 1) check("lat_load", {busy, spd_if.spd_valid}, 2'b10);
            if (chk_lat && c == 2) check("lat_first", {spd_if.spd_valid, spd_if.spd_ch}, 4'b1000);
            if (spd_if.spd_valid && (int'(spd_if.spd_ch) == stall_ch) && stalled < stall_len) begin
                spd_if.spd_ready = 1'b0;
                stalled++;
            end else begin
                spd_if.spd_ready = 1'b1;
            end
        end
        check("burst_timeout", 32'(exp_q.size()), 32'd0);
        check("burst_end_idle", {busy, spd_if.spd_valid, dbg_state}, 4'b0000);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [63:0] cnt;
        logic [63:0] exp;
        bit          prime;
        int          stall_ch;
        int          stall_len;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic seen;

        vecs[0] = '{cnt: 64'h0028_001E_0014_000A, exp: 64'h0,                   prime: 1'b1, stall_ch: -1, stall_len: 0};
        vecs[1] = '{cnt: 64'h008C_001E_0012_000F, exp: 64'h0064_0000_FFFE_0005, prime: 1'b0, stall_ch: -1, stall_len: 0};
        vecs[2] = '{cnt: 64'h8000_1000_0002_FFFE, exp: 64'h7F74_0FE2_FFF0_FFEF, prime: 1'b0, stall_ch: -1, stall_len: 0};
        vecs[3] = '{cnt: 64'h7FF0_0FFF_FFFC_0003, exp: 64'hFFF0_FFFF_FFFA_0005, prime: 1'b0, stall_ch: 1,  stall_len: 5};
        vecs[4] = '{cnt: 64'h7FF0_0FFF_FFFC_0003, exp: 64'h0000_0000_0000_0000, prime: 1'b0, stall_ch: 3,  stall_len: 2};

        reset            = 1'b0;
        enable           = 1'b0;
        clear_ovr        = 1'b0;
        enc_counts       = '0;
        spd_if.spd_ready = 1'b1;

        repeat (3) @(posedge clk);
        #2;
        check("rst_valid",   32'(spd_if.spd_valid), 32'd0);
        check("rst_ch",      32'(spd_if.spd_ch),    32'd0);
        check("rst_data",    32'(spd_if.spd_data),  32'd0);
        check("rst_overrun", 32'(overrun),          32'd0);
        check("rst_busy",    32'(busy),             32'd0);
        check("rst_state",   32'(dbg_state),        32'd0);

        reset = 1'b1;
        @(posedge clk);
        #2;
        enable = 1'b1;

        for (int i = 0; i < 5; i++) begin
            enc_counts = vecs[i].cnt;
            wait_tick($sformatf("tick_v%0d", i));
            if (vecs[i].prime) begin
                prime_check($sformatf("prime_v%0d", i));
            end else begin
                push_exp(vecs[i].exp);
                run_burst(1'b1, vecs[i].stall_ch, vecs[i].stall_len);
            end
        end

        // Overrun: stall across the next tick; the dropped sample is absorbed into the next delta.
        spd_if.spd_ready = 1'b0;
        enc_counts = 64'h7FF0_0FFF_FFFC_0013;
        wait_tick("tick_ovr_a");
        push_exp(64'h0000_0000_0000_0010);
        @(posedge clk);
        #2;
        enc_counts = 64'h7FF0_0FFF_FFFC_0023;
        wait_tick("tick_ovr_drop");
        check("ovr_before", 32'(overrun), 32'd0);
        @(posedge clk);
        #2;
        check("ovr_set", 32'(overrun), 32'd1);
        repeat (3) @(posedge clk);
        #2;
        check("ovr_sticky", 32'(overrun), 32'd1);
        run_burst(1'b0, -1, 0);
        enc_counts = 64'h7FF0_0FFF_FFFC_0033;
        clear_ovr = 1'b1;
        @(posedge clk);
        #2;
        clear_ovr = 1'b0;
        check("ovr_clear", 32'(overrun), 32'd0);
        wait_tick("tick_ovr_b");
        push_exp(64'h0000_0000_0000_0020);
        run_burst(1'b1, -1, 0);

        // Clear and a new overrun in the same cycle: the set must win.
        spd_if.spd_ready = 1'b0;
        wait_tick("tick_sw_a");
        push_exp(64'h0);
        wait_tick("tick_sw_b");
        check("sw_before", 32'(overrun), 32'd0);
        clear_ovr = 1'b1;
        @(posedge clk);
        #2;
        clear_ovr = 1'b0;
        check("ovr_set_wins", 32'(overrun), 32'd1);
        run_burst(1'b0, -1, 0);

        // Disable mid-burst: burst completes, then re-enable only re-primes.
        enc_counts = 64'h0001_0002_0003_0004;
        wait_tick("tick_dis");
        push_exp(64'h8011_F003_0007_FFD1);
        @(posedge clk);
        #2;
        enable = 1'b0;
        run_burst(1'b0, -1, 0);
        seen = 1'b0;
        repeat (2 * PERIOD) begin
            @(posedge clk);
            #2;
            if (busy || spd_if.spd_valid) seen = 1'b1;
        end
        check("dis_quiet", 32'(seen), 32'd0);
        enc_counts = 64'h0100_0200_0300_0400;
        enable = 1'b1;
        wait_tick("tick_reen_prime");
        prime_check("reen_prime");
        enc_counts = 64'h0105_01F0_0300_0500;
        wait_tick("tick_reen");
        push_exp(64'h0005_FFF0_0000_0100);
        run_burst(1'b1, -1, 0);

        // Asynchronous reset while a delta is waiting in SEND.
        spd_if.spd_ready = 1'b0;
        enc_counts = 64'h1111_2222_3333_4444;
        wait_tick("tick_rst");
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        check("rst_pre_valid", 32'(spd_if.spd_valid), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("arst_outputs", {spd_if.spd_valid, busy, overrun, spd_if.spd_ch, spd_if.spd_data},
              32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        spd_if.spd_ready = 1'b1;
        wait_tick("tick_rst_prime");
        prime_check("rst_prime");
        enc_counts = 64'h1115_2225_3335_4445;
        wait_tick("tick_rst_post");
        push_exp(64'h0004_0003_0002_0001);
        run_burst(1'b1, -1, 0);

        check("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
